host_spi_seq: RTL and testbench

HOST_SPI_SEQ -- requirements
Module: host_spi_seq

---
 rtl/host_spi_seq.sv | 187 ++++++++++++++++++
 tb/tb_host_spi_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_spi_seq.sv
// host_spi_seq: queues host register requests and runs them one at a time
// through a downstream SPI master, returning one response per request.
// Latency: push at edge N -> spi_start high for the cycle after edge N+1.
// Backpressure: req_ready drops when the FIFO is full; rsp_valid holds until rsp_ready.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/req_ready              host request handshake
//   req_rw, req_addr, req_wdata      request fields (rw: 1 = read)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rw, rsp_rdata                response fields (rdata is 0 for writes)
//   busy, fifo_level                 status
//   spi_start, spi_tx_data           launch pulse and frame to the SPI master
//   spi_complete, spi_rx_data/valid  completion and read data from the SPI master

// sync_fifo: generic single-clock FIFO with occupancy count.
// Latency: written entry is visible at pop_dat the cycle after the push.
// Backpressure: push_rdy is derived from the registered level only.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  output logic                   push_rdy,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_vld,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Ready comes from the registered level, so a pop while full only frees
  // a slot for the following cycle.
  assign push_rdy = (level < LW'(DEPTH));
  assign push_ok  = push_vld && push_rdy;
  assign pop_ok   = pop_vld && (level != '0);
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module host_spi_seq #(
  parameter int DW    = 38,
  parameter int RX    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rw,
  input  logic [4:0]             req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_rw,
  output logic [RX-1:0]          rsp_rdata,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   spi_start,
  output logic [DW-1:0]          spi_tx_data,
  input  logic                   spi_complete,
  input  logic [RX-1:0]          spi_rx_data,
  input  logic                   spi_rx_valid
);
  typedef struct packed {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } req_t;

  localparam int EW = $bits(req_t);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state;
  req_t            push_dat;
  logic [EW-1:0]   head_raw;
  req_t            head;
  logic [EW-1:0]   frame;
  logic            pop;
  logic            cur_rw;

  assign push_dat = '{rw: req_rw, addr: req_addr, wdata: req_wdata};

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (req_valid),
    .push_rdy (req_ready),
    .push_dat (push_dat),
    .pop_vld  (pop),
    .pop_dat  (head_raw),
    .level    (fifo_level)
  );

  assign head = req_t'(head_raw);

  // The head is consumed on the same edge the FSM leaves IDLE.
  assign pop = (state == IDLE) && (fifo_level != '0);

  // Reads never carry write data onto the wire.
  assign frame = {head.rw, head.addr, (head.rw ? 32'h0 : head.wdata)};

  assign busy = (fifo_level != '0) || (state != IDLE);

  // spi_tx_data is only reloaded when leaving IDLE, so it stays put from
  // LAUNCH through completion. Completion strobes are only looked at in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
      cur_rw      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rw      <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_level != '0) begin
            spi_tx_data <= DW'(frame);
            cur_rw      <= head.rw;
            spi_start   <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          spi_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (spi_complete) begin
            rsp_rw    <= cur_rw;
            rsp_rdata <= (cur_rw && spi_rx_valid) ? spi_rx_data : '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_host_spi_seq.sv
// Directed bench for host_spi_seq: the bench plays host and SPI master,
// queuing expected frames on push and expected responses on completion.
module tb_host_spi_seq;
  localparam int DW    = 38;
  localparam int RX    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [4:0]    req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_rw;
  logic [RX-1:0] rsp_rdata;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          spi_start;
  logic [DW-1:0] spi_tx_data;
  logic          spi_complete = 1'b0;
  logic [RX-1:0] spi_rx_data = '0;
  logic          spi_rx_valid = 1'b0;

  always #5 clk = ~clk;

  host_spi_seq #(.DW(DW), .RX(RX), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rw       (rsp_rw),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .spi_start    (spi_start),
    .spi_tx_data  (spi_tx_data),
    .spi_complete (spi_complete),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q_frame[$];    // expected frames, in push order
  logic [RX:0]   q_rsp[$];      // expected {rw, rdata}
  logic [DW-1:0] q_started[$];  // frames seen on spi_start (monitor only)
  int            n_seen = 0;    // entries of q_started already consumed
  int            n_start = 0;
  int            max_level = 0;

  always @(negedge clk) begin
    if (spi_start) begin
      q_started.push_back(spi_tx_data);
      n_start++;
    end
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_frame(input logic rw, input logic [4:0] a,
                                                input logic [31:0] d);
    return {rw, a, (rw ? 32'h0 : d)};
  endfunction

  // Drives one request across a clock edge; req_valid is left high so
  // consecutive calls make back-to-back pushes.
  task automatic push_one(input logic rw, input logic [4:0] a, input logic [31:0] d);
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    check("req_ready_before_push", 64'(req_ready), 64'(1));
    tick();
    q_frame.push_back(model_frame(rw, a, d));
  endtask

  task automatic spi_serve(input logic [RX-1:0] rx, input logic rxv, input int delay);
    logic [DW-1:0] f;
    logic [DW-1:0] e;
    int cnt = 0;
    while (q_started.size() <= n_seen && cnt < 60) begin
      tick();
      cnt++;
    end
    check("start_seen", 64'(q_started.size() > n_seen), 64'(1));
    if (q_started.size() <= n_seen || q_frame.size() == 0) return;
    f = q_started[n_seen];
    n_seen++;
    e = q_frame.pop_front();
    check("tx_frame_order", 64'(f), 64'(e));
    check("start_one_cycle", 64'(spi_start), 64'(0));
    repeat (delay) tick();
    spi_rx_data  = rx;
    spi_rx_valid = rxv;
    spi_complete = 1'b1;
    tick();
    spi_complete = 1'b0;
    spi_rx_valid = 1'b0;
    spi_rx_data  = '0;
    check("tx_stable_after_complete", 64'(spi_tx_data), 64'(f));
    q_rsp.push_back({e[DW-1], ((e[DW-1] && rxv) ? rx : 16'h0)});
  endtask

  task automatic rsp_take(input int hold);
    logic [RX:0] e;
    int cnt = 0;
    int s0;
    while (!rsp_valid && cnt < 60) begin
      tick();
      cnt++;
    end
    check("rsp_seen", 64'(rsp_valid), 64'(1));
    if (!rsp_valid || q_rsp.size() == 0) return;
    e = q_rsp.pop_front();
    check("rsp_rw", 64'(rsp_rw), 64'(e[RX]));
    check("rsp_rdata", 64'(rsp_rdata), 64'(e[RX-1:0]));
    s0 = n_start;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp_rdata", 64'({rsp_rw, rsp_rdata}), 64'(e));
    end
    check("no_start_while_held", 64'(n_start), 64'(s0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_drop_after_accept", 64'(rsp_valid), 64'(0));
  endtask

  task automatic check_reset_values(input string phase);
    check({phase, "_spi_start"},   64'(spi_start),   64'(0));
    check({phase, "_spi_tx_data"}, 64'(spi_tx_data), 64'(0));
    check({phase, "_rsp_valid"},   64'(rsp_valid),   64'(0));
    check({phase, "_rsp_rdata"},   64'(rsp_rdata),   64'(0));
    check({phase, "_rsp_rw"},      64'(rsp_rw),      64'(0));
    check({phase, "_busy"},        64'(busy),        64'(0));
    check({phase, "_req_ready"},   64'(req_ready),   64'(1));
    check({phase, "_fifo_level"},  64'(fifo_level),  64'(0));
  endtask

  initial begin
    // ---- reset ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // ---- write: latency and frame ----
    push_one(1'b0, 5'h03, 32'hDEADBEEF);
    req_valid = 1'b0;
    check("lat_edge_n_start", 64'(spi_start), 64'(0));
    check("lat_edge_n_level", 64'(fifo_level), 64'(1));
    check("lat_edge_n_busy", 64'(busy), 64'(1));
    tick();
    check("lat_edge_n1_start", 64'(spi_start), 64'(1));
    check("write_frame", 64'(spi_tx_data), 64'(38'h03_DEADBEEF));
    spi_serve(16'h1234, 1'b1, 3);
    check("write_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("write_rsp_rw", 64'(rsp_rw), 64'(0));
    rsp_take(0);

    // ---- read: wdata masked, rx data returned ----
    push_one(1'b1, 5'h1F, 32'hFFFFFFFF);
    req_valid = 1'b0;
    tick();
    check("read_start", 64'(spi_start), 64'(1));
    check("read_frame", 64'(spi_tx_data), 64'(38'h3F_00000000));
    spi_serve(16'hA5C3, 1'b1, 2);
    check("read_rsp_rdata", 64'(rsp_rdata), 64'(16'hA5C3));
    check("read_rsp_rw", 64'(rsp_rw), 64'(1));
    rsp_take(0);

    // ---- backpressure with a second request queued behind ----
    push_one(1'b1, 5'h07, 32'h0);
    push_one(1'b0, 5'h08, 32'h55AA55AA);
    req_valid = 1'b0;
    spi_serve(16'h0F0F, 1'b1, 1);
    rsp_take(20);
    spi_serve(16'h7777, 1'b1, 0);
    rsp_take(0);

    // ---- spurious completion in IDLE ----
    spi_complete = 1'b1;
    spi_rx_valid = 1'b1;
    spi_rx_data  = 16'hFFFF;
    tick();
    spi_complete = 1'b0;
    spi_rx_valid = 1'b0;
    spi_rx_data  = '0;
    repeat (3) tick();
    check("spurious_rsp_valid", 64'(rsp_valid), 64'(0));
    check("spurious_busy", 64'(busy), 64'(0));
    check("spurious_no_start", 64'(q_started.size()), 64'(n_seen));

    // ---- fill: five back-to-back pushes, no completions ----
    for (int i = 0; i < 5; i++) begin
      push_one(i[0], 5'(i + 16), $urandom);
      if (i == 1) check("push_pop_level_same", 64'(fifo_level), 64'(1));
    end
    req_rw = 1'b0;
    req_addr = 5'h1E;
    check("full_ready_low", 64'(req_ready), 64'(0));
    check("full_level", 64'(fifo_level), 64'(DEPTH));
    repeat (3) tick();
    req_valid = 1'b0;
    check("full_no_overflow", 64'(fifo_level), 64'(DEPTH));
    for (int i = 0; i < 5; i++) begin
      spi_serve(16'(16'h1000 + i), 1'b1, 2);
      rsp_take(0);
    end
    check("max_level", 64'(max_level), 64'(DEPTH));
    check("fill_drained_level", 64'(fifo_level), 64'(0));

    // ---- reset in WAIT with three queued requests ----
    for (int i = 0; i < 4; i++) push_one(1'b0, 5'(i), 32'(i + 100));
    req_valid = 1'b0;
    check("prereset_level", 64'(fifo_level), 64'(3));
    check("prereset_started", 64'(q_started.size()), 64'(n_seen + 1));
    #2 rst = 1'b1;
    #1 check_reset_values("midreset");
    n_seen = q_started.size();
    q_frame.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) tick();
    check("postreset_no_start", 64'(q_started.size()), 64'(n_seen));
    check("postreset_level", 64'(fifo_level), 64'(0));
    check("postreset_rsp_valid", 64'(rsp_valid), 64'(0));

    // ---- read with spi_rx_valid low returns zero ----
    push_one(1'b1, 5'h0A, 32'h00000123);
    req_valid = 1'b0;
    spi_serve(16'hBEEF, 1'b0, 1);
    rsp_take(0);
    check("final_idle_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
